// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared definitions for the VGA receiver and generator:
//                default active-area sizes, counter widths and receiver
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ATIVO_PADRAO = 640;   // active pixels per line
    localparam int V_ATIVO_PADRAO = 480;   // active lines per frame
    localparam int CONT_W         = 10;    // coordinate counter width
    localparam int ERR_W          = 8;     // error counter width

    typedef logic [CONT_W-1:0] cont_t;

    typedef enum logic [1:0] {
        AGUARDA_QUADRO = 2'd0,
        AGUARDA_LINHA  = 2'd1,
        ATIVO          = 2'd2
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/detector_borda.sv
`default_nettype none
// ============================================================================
//  Module      : detector_borda
//  Description : Edge detector for an already-registered signal. Keeps a
//                one-cycle-delayed copy and flags rising/falling edges by
//                comparing the two.
//  Ports       : Clock, Reset (async, active-high)
//                sinal_i  - registered input signal
//                sobe_o   - high for one cycle after a 0->1 change
//                desce_o  - high for one cycle after a 1->0 change
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_borda #(
    parameter logic VALOR_RESET = 1'b0   // idle level of the watched signal
) (
    input  logic Clock,
    input  logic Reset,
    input  logic sinal_i,
    output logic sobe_o,
    output logic desce_o
);

    logic sinal_dly_q;

    // Reset to the idle level so releasing reset never fakes an edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sinal_dly_q <= VALOR_RESET;
        end else begin
            sinal_dly_q <= sinal_i;
        end
    end

    assign sobe_o  = sinal_i & ~sinal_dly_q;
    assign desce_o = ~sinal_i & sinal_dly_q;

endmodule
`default_nettype wire

// File: rtl/vga_receptor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_receptor
//  Description : VGA capture receiver. Registers the VGA pins, tracks lines
//                and frames from blank/v_sync edges, emits captured pixels
//                with coordinates and checks the frame timing.
//  Ports       : Clock, Reset (async, active-high)
//                h_sync, v_sync (active-low), blank (high = active video),
//                R, G, B        - pixel colour inputs
//                PixelRGB       - captured pixel {B,G,R}
//                Linha, Coluna  - coordinates of PixelRGB
//                PixelValido    - PixelRGB/Linha/Coluna valid this cycle
//                FimLinha, FimQuadro - single-cycle end markers
//                Travado        - locked to a correct frame
//                ErroTiming     - single-cycle timing-violation pulse
//                ContErros      - saturating count of ErroTiming pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_receptor
    import vga_pkg::*;
#(
    parameter int H_ATIVO = H_ATIVO_PADRAO,
    parameter int V_ATIVO = V_ATIVO_PADRAO
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              blank,
    input  logic [7:0]        R,
    input  logic [7:0]        G,
    input  logic [7:0]        B,
    output logic [23:0]       PixelRGB,
    output logic [CONT_W-1:0] Linha,
    output logic [CONT_W-1:0] Coluna,
    output logic              PixelValido,
    output logic              FimLinha,
    output logic              FimQuadro,
    output logic              Travado,
    output logic              ErroTiming,
    output logic [ERR_W-1:0]  ContErros
);

    localparam cont_t H_LIM = cont_t'(H_ATIVO);
    localparam cont_t V_LIM = cont_t'(V_ATIVO);

    // ---------------- input stage ----------------
    logic       h_q, v_q, blank_q, h_dly_q;
    logic [7:0] r_q, g_q, b_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            h_q     <= 1'b1;
            v_q     <= 1'b1;
            blank_q <= 1'b0;
            h_dly_q <= 1'b1;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            h_q     <= h_sync;
            v_q     <= v_sync;
            blank_q <= blank;
            h_dly_q <= h_q;
            r_q     <= R;
            g_q     <= G;
            b_q     <= B;
        end
    end

    logic w_v_sobe, w_v_desce, w_blank_sobe, w_blank_desce, w_h_desce;

    detector_borda #(.VALOR_RESET(1'b1)) u_borda_vsync (
        .Clock  (Clock),
        .Reset  (Reset),
        .sinal_i(v_q),
        .sobe_o (w_v_sobe),
        .desce_o(w_v_desce)
    );

    detector_borda #(.VALOR_RESET(1'b0)) u_borda_blank (
        .Clock  (Clock),
        .Reset  (Reset),
        .sinal_i(blank_q),
        .sobe_o (w_blank_sobe),
        .desce_o(w_blank_desce)
    );

    assign w_h_desce = h_dly_q & ~h_q;

    // ---------------- tracking FSM ----------------
    estado_t estado_q, estado_d;
    cont_t   col_q, col_d, lin_q, lin_d;
    logic    col_ovf_q, col_ovf_d;       // blank held past H_ATIVO pixels
    logic    lin_ovf_q, lin_ovf_d;       // a line ended with counter saturated
    logic    quadro_err_q, quadro_err_d; // frame already had a reported error
    logic    travado_q, travado_d;

    logic w_passo, w_valido, w_fim_linha, w_fim_quadro;
    logic w_err_linha, w_err_quadro, w_err_hs, w_err;

    always_comb begin
        estado_d     = estado_q;
        col_d        = col_q;
        lin_d        = lin_q;
        col_ovf_d    = col_ovf_q;
        lin_ovf_d    = lin_ovf_q;
        quadro_err_d = quadro_err_q;
        travado_d    = travado_q;
        w_passo      = 1'b0;
        w_valido     = 1'b0;
        w_fim_linha  = 1'b0;
        w_fim_quadro = 1'b0;
        w_err_linha  = 1'b0;
        w_err_quadro = 1'b0;
        w_err_hs     = w_h_desce & blank_q;

        case (estado_q)
            AGUARDA_QUADRO: begin
                if (w_v_sobe) begin
                    estado_d     = AGUARDA_LINHA;
                    lin_d        = '0;
                    col_d        = '0;
                    col_ovf_d    = 1'b0;
                    lin_ovf_d    = 1'b0;
                    quadro_err_d = 1'b0;
                end
            end
            AGUARDA_LINHA: begin
                if (w_v_desce) begin
                    // Frame check. A frame whose error was already reported
                    // mid-frame is not counted as correct, but is not
                    // reported a second time.
                    if ((lin_q != V_LIM) || lin_ovf_q) begin
                        w_err_quadro = 1'b1;
                        travado_d    = 1'b0;
                    end else if (quadro_err_q) begin
                        travado_d    = 1'b0;
                    end else begin
                        w_fim_quadro = 1'b1;
                        travado_d    = 1'b1;
                    end
                    lin_d        = '0;
                    lin_ovf_d    = 1'b0;
                    quadro_err_d = 1'b0;
                end else if (w_blank_sobe) begin
                    // First pixel is already on blank_q; capture it now to
                    // keep the pin-to-output latency fixed.
                    estado_d = ATIVO;
                    w_passo  = 1'b1;
                end
            end
            ATIVO: begin
                if (w_v_desce) begin
                    w_err_quadro = 1'b1;
                    travado_d    = 1'b0;
                    estado_d     = AGUARDA_LINHA;
                    lin_d        = '0;
                    col_d        = '0;
                    col_ovf_d    = 1'b0;
                    lin_ovf_d    = 1'b0;
                    quadro_err_d = 1'b0;
                end else if (w_blank_desce) begin
                    w_fim_linha = 1'b1;
                    w_err_linha = (col_q != H_LIM) || col_ovf_q;
                    if (lin_q == V_LIM) begin
                        lin_ovf_d = 1'b1;
                    end else begin
                        lin_d = lin_q + 1'b1;
                    end
                    col_d     = '0;
                    col_ovf_d = 1'b0;
                    estado_d  = AGUARDA_LINHA;
                end else if (blank_q) begin
                    w_passo = 1'b1;
                end
            end
            default: begin
                estado_d = AGUARDA_QUADRO;
            end
        endcase

        if (w_passo) begin
            if (col_q < H_LIM) begin
                w_valido = (lin_q < V_LIM);
                col_d    = col_q + 1'b1;
            end else begin
                col_ovf_d = 1'b1;
            end
        end

        w_err = w_err_linha | w_err_quadro | w_err_hs;
        if (w_err_linha || w_err_hs) begin
            quadro_err_d = 1'b1;
        end
        if (w_err) begin
            travado_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_q     <= AGUARDA_QUADRO;
            col_q        <= '0;
            lin_q        <= '0;
            col_ovf_q    <= 1'b0;
            lin_ovf_q    <= 1'b0;
            quadro_err_q <= 1'b0;
            travado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            col_q        <= col_d;
            lin_q        <= lin_d;
            col_ovf_q    <= col_ovf_d;
            lin_ovf_q    <= lin_ovf_d;
            quadro_err_q <= quadro_err_d;
            travado_q    <= travado_d;
        end
    end

    // ---------------- output stage ----------------
    logic [23:0]      pixel_q;
    cont_t            linha_q, coluna_q;
    logic             valido_q, fim_linha_q, fim_quadro_q, erro_q;
    logic [ERR_W-1:0] cont_err_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pixel_q      <= '0;
            linha_q      <= '0;
            coluna_q     <= '0;
            valido_q     <= 1'b0;
            fim_linha_q  <= 1'b0;
            fim_quadro_q <= 1'b0;
            erro_q       <= 1'b0;
            cont_err_q   <= '0;
        end else begin
            valido_q     <= w_valido;
            fim_linha_q  <= w_fim_linha;
            fim_quadro_q <= w_fim_quadro;
            erro_q       <= w_err;
            if (w_valido) begin
                pixel_q  <= {b_q, g_q, r_q};
                linha_q  <= lin_q;
                coluna_q <= col_q;
            end
            if (w_err && (cont_err_q != {ERR_W{1'b1}})) begin
                cont_err_q <= cont_err_q + 1'b1;
            end
        end
    end

    assign PixelRGB    = pixel_q;
    assign Linha       = linha_q;
    assign Coluna      = coluna_q;
    assign PixelValido = valido_q;
    assign FimLinha    = fim_linha_q;
    assign FimQuadro   = fim_quadro_q;
    assign Travado     = travado_q;
    assign ErroTiming  = erro_q;
    assign ContErros   = cont_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_receptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_receptor
//  Description : Directed self-checking bench for vga_receptor using a
//                reduced 8x4 active area.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_receptor;

    localparam int H = 8;
    localparam int V = 4;

    logic        Clock = 1'b0;
    logic        Reset, h_sync, v_sync, blank;
    logic [7:0]  R, G, B;
    logic [23:0] PixelRGB;
    logic [9:0]  Linha, Coluna;
    logic        PixelValido, FimLinha, FimQuadro, Travado, ErroTiming;
    logic [7:0]  ContErros;

    always #5 Clock = ~Clock;

    vga_receptor #(.H_ATIVO(H), .V_ATIVO(V)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .blank      (blank),
        .R          (R),
        .G          (G),
        .B          (B),
        .PixelRGB   (PixelRGB),
        .Linha      (Linha),
        .Coluna     (Coluna),
        .PixelValido(PixelValido),
        .FimLinha   (FimLinha),
        .FimQuadro  (FimQuadro),
        .Travado    (Travado),
        .ErroTiming (ErroTiming),
        .ContErros  (ContErros)
    );

    typedef struct packed {
        logic [9:0]  lin;
        logic [9:0]  col;
        logic [23:0] rgb;
        logic [31:0] cyc;
    } pix_t;

    pix_t fila[$];
    pix_t esp;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    int   pix_cnt = 0, fl_cnt = 0, fq_cnt = 0, err_cnt = 0;
    int   b_pix, b_fl, b_fq, b_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge Clock) cyc <= cyc + 1;

    // Pixel scoreboard and pulse counters
    always @(negedge Clock) begin
        if (PixelValido === 1'b1) begin
            pix_cnt++;
            if (fila.size() == 0) begin
                chk("pix_extra", 32'd1, 32'd0);
            end else begin
                esp = fila.pop_front();
                chk("pix_rgb", {8'd0, PixelRGB}, {8'd0, esp.rgb});
                chk("pix_lin", {22'd0, Linha}, {22'd0, esp.lin});
                chk("pix_col", {22'd0, Coluna}, {22'd0, esp.col});
                chk("pix_lat", cyc, esp.cyc + 32'd2);
            end
        end
        if (FimLinha === 1'b1)   fl_cnt++;
        if (FimQuadro === 1'b1)  fq_cnt++;
        if (ErroTiming === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic marca();
        b_pix = pix_cnt; b_fl = fl_cnt; b_fq = fq_cnt; b_err = err_cnt;
    endtask

    task automatic deltas(input string tag, input int pix, input int fl, input int fq, input int err);
        chk({tag, "_pix"}, pix_cnt - b_pix, pix);
        chk({tag, "_fl"},  fl_cnt - b_fl,   fl);
        chk({tag, "_fq"},  fq_cnt - b_fq,   fq);
        chk({tag, "_err"}, err_cnt - b_err, err);
    endtask

    // One line: n pixels of blank high, then a 6-cycle porch with an h_sync
    // pulse (or the pulse inside the active part when hs is set).
    task automatic drive_line(input int n, input int l, input bit push, input bit hs);
        for (int c = 0; c < n; c++) begin
            tick();
            blank  = 1'b1;
            R      = 8'(l);
            G      = 8'(c);
            B      = 8'hA5;
            h_sync = !(hs && (c == 2 || c == 3));
            if (push && c < H)
                fila.push_back({10'(l), 10'(c), {8'hA5, 8'(c), 8'(l)}, 32'(cyc)});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            blank  = 1'b0;
            h_sync = !(!hs && (i == 2 || i == 3));
        end
    endtask

    task automatic vsync();
        tick(); blank = 1'b0; v_sync = 1'b0;
        tick(); v_sync = 1'b0;
        tick(); v_sync = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic frame(input int n_lin, input int long_l, input int hs_l);
        for (int l = 0; l < n_lin; l++)
            drive_line((l == long_l) ? H + 1 : H, l, l < V, l == hs_l);
        vsync();
    endtask

    initial begin
        Reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1; blank = 1'b0;
        R = '0; G = '0; B = '0;

        // Reset state
        tick(); tick();
        chk("rst_rgb", {8'd0, PixelRGB}, 32'd0);
        chk("rst_lin", {22'd0, Linha}, 32'd0);
        chk("rst_col", {22'd0, Coluna}, 32'd0);
        chk("rst_val", {31'd0, PixelValido}, 32'd0);
        chk("rst_fl",  {31'd0, FimLinha}, 32'd0);
        chk("rst_fq",  {31'd0, FimQuadro}, 32'd0);
        chk("rst_trv", {31'd0, Travado}, 32'd0);
        chk("rst_err", {31'd0, ErroTiming}, 32'd0);
        chk("rst_cnt", {24'd0, ContErros}, 32'd0);
        Reset = 1'b0;
        tick();

        // Lines before the first v_sync rising edge are ignored
        marca();
        drive_line(H, 0, 1'b0, 1'b0);
        deltas("prelock", 0, 0, 0, 0);
        vsync();

        // Two correct frames
        marca();
        frame(V, -1, -1);
        chk("f1_trv", {31'd0, Travado}, 32'd1);
        frame(V, -1, -1);
        deltas("good2", 2 * H * V, 2 * V, 2, 0);
        chk("good_trv", {31'd0, Travado}, 32'd1);
        chk("good_cnt", {24'd0, ContErros}, 32'd0);

        // One line with H+1 active pixels
        marca();
        frame(V, 1, -1);
        deltas("long", H * V, V, 0, 1);
        chk("long_trv", {31'd0, Travado}, 32'd0);
        chk("long_cnt", {24'd0, ContErros}, 32'd1);

        // Short frame, then a correct one relocks
        marca();
        frame(V - 1, -1, -1);
        deltas("short", H * (V - 1), V - 1, 0, 1);
        chk("short_trv", {31'd0, Travado}, 32'd0);
        chk("short_cnt", {24'd0, ContErros}, 32'd2);
        marca();
        frame(V, -1, -1);
        deltas("relock", H * V, V, 1, 0);
        chk("relock_trv", {31'd0, Travado}, 32'd1);

        // Extra line: no pixels on it, error at frame check
        marca();
        frame(V + 1, -1, -1);
        deltas("extra", H * V, V + 1, 0, 1);
        chk("extra_trv", {31'd0, Travado}, 32'd0);
        chk("extra_cnt", {24'd0, ContErros}, 32'd3);

        // h_sync pulse during active video
        marca();
        frame(V, -1, 0);
        deltas("hs", H * V, V, 0, 1);
        chk("hs_cnt", {24'd0, ContErros}, 32'd4);

        // v_sync falls while in an active line
        marca();
        for (int c = 0; c < 3; c++) begin
            tick(); blank = 1'b1; R = 8'd0; G = 8'(c); B = 8'hA5;
            fila.push_back({10'd0, 10'(c), {8'hA5, 8'(c), 8'd0}, 32'(cyc)});
        end
        tick(); blank = 1'b0; v_sync = 1'b0;
        tick();
        tick(); v_sync = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        deltas("vact", 3, 0, 0, 1);
        chk("vact_trv", {31'd0, Travado}, 32'd0);
        chk("vact_cnt", {24'd0, ContErros}, 32'd5);
        marca();
        frame(V, -1, -1);
        deltas("vact_rec", H * V, V, 1, 0);
        chk("vact_rec_trv", {31'd0, Travado}, 32'd1);

        // Reset in the middle of line 2
        drive_line(H, 0, 1'b1, 1'b0);
        drive_line(H, 1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick(); blank = 1'b1; R = 8'd2; G = 8'(c); B = 8'hA5;
            fila.push_back({10'd2, 10'(c), {8'hA5, 8'(c), 8'd2}, 32'(cyc)});
        end
        tick();
        Reset = 1'b1;
        fila.delete();
        #1;
        chk("mrst_val", {31'd0, PixelValido}, 32'd0);
        chk("mrst_lin", {22'd0, Linha}, 32'd0);
        chk("mrst_col", {22'd0, Coluna}, 32'd0);
        chk("mrst_rgb", {8'd0, PixelRGB}, 32'd0);
        chk("mrst_trv", {31'd0, Travado}, 32'd0);
        tick(); tick();
        Reset = 1'b0;
        marca();
        for (int c = 0; c < 3; c++) tick();
        blank = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        drive_line(H, 0, 1'b0, 1'b0);
        deltas("postrst", 0, 0, 0, 0);
        vsync();
        marca();
        frame(V, -1, -1);
        deltas("postrst_f", H * V, V, 1, 0);
        chk("postrst_cnt", {24'd0, ContErros}, 32'd0);

        // 300 short lines saturate the error counter
        marca();
        for (int l = 0; l < 300; l++) drive_line(H - 1, l, l < V, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_err", err_cnt - b_err, 300);
        chk("sat_cnt", {24'd0, ContErros}, 32'd255);

        for (int i = 0; i < 4; i++) tick();
        chk("q_empty", fila.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/vga_receptor.md
VGA_RECEPTOR -- requirements
Module: vga_receptor

Interface
REQ-001 SHALL have parameter H_ATIVO, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ATIVO, default 480, active lines per frame.
REQ-003 SHALL have port Clock  input  1  pixel clock (25 MHz); all sampling on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports h_sync, v_sync  input  1 each  VGA syncs, active-low pulses.
REQ-006 SHALL have port blank  input  1  high = active video (BLANK_N sense).
REQ-007 SHALL have ports R, G, B  input  8 each  pixel colour.
REQ-008 SHALL have port PixelRGB  output  24  captured pixel, packed {B,G,R} (BMP order).
REQ-009 SHALL have ports Linha, Coluna  output  10 each  coordinates of PixelRGB.
REQ-010 SHALL have port PixelValido  output  1  PixelRGB/Linha/Coluna valid this cycle.
REQ-011 SHALL have ports FimLinha, FimQuadro  output  1 each  single-cycle end markers.
REQ-012 SHALL have port Travado  output  1  receiver locked to a correct frame.
REQ-013 SHALL have port ErroTiming  output  1  single-cycle pulse on any timing violation.
REQ-014 SHALL have port ContErros  output  8  saturating count of ErroTiming pulses.

Function
REQ-015 SHALL register h_sync, v_sync, blank, R, G, B in one input stage; edge detection compares the registered value with its one-cycle-delayed copy.
REQ-016 SHALL implement states AGUARDA_QUADRO, AGUARDA_LINHA, ATIVO.
REQ-017 AGUARDA_QUADRO: no PixelValido; on v_sync rising edge (end of pulse) -> AGUARDA_LINHA, line counter = 0.
REQ-018 AGUARDA_LINHA: on blank rising edge -> ATIVO, column counter = 0; on v_sync falling edge -> frame check (REQ-022).
REQ-019 ATIVO: each cycle with registered blank=1 and column counter < H_ATIVO SHALL assert PixelValido with Coluna = column counter, Linha = line counter, then increment column counter.
REQ-020 PixelValido SHALL appear exactly 2 Clock cycles after the pixel is present on the pins (input stage + output stage).
REQ-021 On blank falling edge in ATIVO: pulse FimLinha; if column count != H_ATIVO pulse ErroTiming; increment line counter; -> AGUARDA_LINHA.
REQ-022 On v_sync falling edge: if line count == V_ATIVO pulse FimQuadro and set Travado, else pulse ErroTiming and clear Travado; -> AGUARDA_LINHA with line counter = 0.
REQ-023 Column overflow: blank held beyond H_ATIVO pixels SHALL suppress PixelValido, hold counter at H_ATIVO, and flag error at line end (single pulse).
REQ-024 Line overflow: lines beyond V_ATIVO-1 SHALL not assert PixelValido; line counter saturates at V_ATIVO; error reported at frame check.
REQ-025 v_sync falling edge while in ATIVO SHALL pulse ErroTiming, clear Travado, and perform no FimLinha.
REQ-026 Simultaneous ErroTiming sources in one cycle SHALL produce one pulse and increment ContErros by one.
REQ-027 ContErros SHALL saturate at 255; it clears only on reset.
REQ-028 h_sync SHALL be used only to check that no h_sync pulse occurs while blank=1; a violation pulses ErroTiming.

Reset
REQ-029 Reset SHALL asynchronously force state AGUARDA_QUADRO, all counters 0, PixelRGB 0, Linha 0, Coluna 0, all 1-bit outputs 0, ContErros 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release no PixelValido until a v_sync rising edge is seen.

Structure
REQ-031 H_ATIVO/V_ATIVO defaults, state encoding and counter widths SHALL live in shared package vga_pkg, also used by Interface_VGA.
REQ-032 SHALL instantiate sub-module detector_borda (registered rising/falling edge pulses) once each for blank and v_sync.

Verification
REQ-033 Reset, then two 640x480 frames from Interface_VGA with RGB = {Linha[7:0], Coluna[7:0], 8'hA5} -> 307200 PixelValido per frame, every pixel matches, Travado=1 after first FimQuadro, ContErros=0.
REQ-034 Single line with blank high 641 pixels -> exactly 640 PixelValido on that line, one ErroTiming, ContErros=1, Travado=0 at next frame check.
REQ-035 Frame with 479 active lines -> no FimQuadro, one ErroTiming at v_sync fall, Travado=0; next correct frame -> Travado=1.
REQ-036 Reset asserted at Linha=200, Coluna=300 for 3 cycles -> all outputs 0 immediately; first PixelValido after release has Linha=0, Coluna=0.
REQ-037 Force 300 line-length errors -> ContErros=255, no wrap.
REQ-038 Pixel driven at pin cycle n at position (0,0) -> PixelValido with PixelRGB={B,G,R} at cycle n+2.
